// File: rtl/lfsr_pkg.sv
// Shared Galois LFSR types and helpers.
// Single-step function is width-agnostic up to MAX_W bits.
package lfsr_pkg;

  localparam int MAX_W = 64;

  localparam logic [31:0] POLY_32 = 32'h8020_0003;
  localparam logic [15:0] POLY_16 = 16'hB400;

  function automatic logic [MAX_W-1:0] galois_step(
    input logic [MAX_W-1:0] s,
    input logic [MAX_W-1:0] poly,
    input int               w
  );
    logic [MAX_W-1:0] sh;
    logic [MAX_W-1:0] r;
    sh = s >> 1;
    r  = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w - 1) begin
        r[i] = sh[i] ^ (poly[i] & s[0]);
      end else if (i == w - 1) begin
        r[i] = s[0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/galois_lfsr_stream_if.sv
// Control and valid/ready stream bundle of the LFSR source.
// slave = generator side, master = controller/consumer side.
interface galois_lfsr_stream_if #(
  parameter int WIDTH = 32,
  parameter int OUT_W = WIDTH
);

  logic             enable;
  logic             seed_load;
  logic [WIDTH-1:0] seed_in;
  logic [OUT_W-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             seed_zero;
  logic             period_done;
  logic [WIDTH-1:0] state;

  modport master (
    output enable,
    output seed_load,
    output seed_in,
    output dout_ready,
    input  dout,
    input  dout_valid,
    input  seed_zero,
    input  period_done,
    input  state
  );

  modport slave (
    input  enable,
    input  seed_load,
    input  seed_in,
    input  dout_ready,
    output dout,
    output dout_valid,
    output seed_zero,
    output period_done,
    output state
  );

endinterface

// File: rtl/galois_lfsr_multistep.sv
// Combinational STEPS-deep Galois LFSR chain.
// Reusable by parallel scramblers.
module galois_lfsr_multistep
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(POLY_32),
  parameter int               STEPS = 1
) (
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] chain [STEPS+1];

  assign chain[0] = din;

  for (genvar k = 0; k < STEPS; k++) begin : g_step
    assign chain[k+1] = WIDTH'(galois_step(
      MAX_W'(chain[k]), MAX_W'(POLY), WIDTH));
  end

  assign dout = chain[STEPS];

endmodule

// File: rtl/galois_lfsr_stream.sv
// Galois LFSR stream source: seed load, lock-up
// recovery, period-complete pulse, STEPS per word.
module galois_lfsr_stream
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(POLY_32),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
  parameter int               STEPS = 1,
  parameter int               OUT_W = WIDTH
) (
  input logic                  clk,
  input logic                  reset,
  galois_lfsr_stream_if.slave  bus
);

  if (WIDTH < 3 || WIDTH > MAX_W) begin : g_chk_w
    $error("WIDTH out of range");
  end
  if (POLY[WIDTH-1] != 1'b1) begin : g_chk_poly
    $error("POLY top bit must be set");
  end
  if (STEPS < 1 || STEPS > WIDTH) begin : g_chk_steps
    $error("STEPS out of range");
  end
  if (OUT_W < 1 || OUT_W > WIDTH) begin : g_chk_outw
    $error("OUT_W out of range");
  end
  if (SEED == '0) begin : g_chk_seed
    $error("SEED must be nonzero");
  end

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic             valid_q, valid_d;
  logic             seed_zero_q, seed_zero_d;
  logic             period_done_q, period_done_d;

  logic [WIDTH-1:0] step_nxt;
  logic [WIDTH-1:0] load_val;
  logic             seed_is_zero;
  logic             accept;

  galois_lfsr_multistep #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .STEPS (STEPS)
  ) u_step (
    .din  (state_q),
    .dout (step_nxt)
  );

  assign seed_is_zero = (bus.seed_in == '0);
  assign load_val     = seed_is_zero ? SEED : bus.seed_in;
  assign accept       = valid_q & bus.dout_ready;

  // Load beats lock-up recovery beats advance.
  always_comb begin
    state_d       = state_q;
    seed_d        = seed_q;
    valid_d       = bus.enable;
    seed_zero_d   = 1'b0;
    period_done_d = 1'b0;
    if (bus.seed_load) begin
      state_d     = load_val;
      seed_d      = load_val;
      seed_zero_d = seed_is_zero;
      valid_d     = 1'b0;
    end else if (state_q == '0) begin
      state_d = SEED;
    end else if (accept) begin
      state_d       = step_nxt;
      period_done_d = (step_nxt == seed_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SEED;
      seed_q        <= SEED;
      valid_q       <= 1'b0;
      seed_zero_q   <= 1'b0;
      period_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      seed_q        <= seed_d;
      valid_q       <= valid_d;
      seed_zero_q   <= seed_zero_d;
      period_done_q <= period_done_d;
    end
  end

  assign bus.dout        = state_q[OUT_W-1:0];
  assign bus.dout_valid  = valid_q;
  assign bus.seed_zero   = seed_zero_q;
  assign bus.period_done = period_done_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_galois_lfsr_stream.sv
// Bench for galois_lfsr_stream: directed literal checks
// plus randomized traffic against a behavioural model.
module tb_galois_lfsr_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [3];
  logic        en  [3];
  logic        ld  [3];
  logic        rdy [3];
  logic [63:0] sin [3];

  logic [63:0] a_dout  [3];
  logic [63:0] a_state [3];
  logic        a_v [3];
  logic        a_z [3];
  logic        a_p [3];

  galois_lfsr_stream_if #(.WIDTH(32)) if0 ();
  galois_lfsr_stream_if #(.WIDTH(4))  if1 ();
  galois_lfsr_stream_if #(.WIDTH(4))  if2 ();

  assign if0.enable     = en[0];
  assign if0.seed_load  = ld[0];
  assign if0.seed_in    = sin[0][31:0];
  assign if0.dout_ready = rdy[0];
  assign if1.enable     = en[1];
  assign if1.seed_load  = ld[1];
  assign if1.seed_in    = sin[1][3:0];
  assign if1.dout_ready = rdy[1];
  assign if2.enable     = en[2];
  assign if2.seed_load  = ld[2];
  assign if2.seed_in    = sin[2][3:0];
  assign if2.dout_ready = rdy[2];

  assign a_dout[0]  = 64'(if0.dout);
  assign a_state[0] = 64'(if0.state);
  assign a_v[0]     = if0.dout_valid;
  assign a_z[0]     = if0.seed_zero;
  assign a_p[0]     = if0.period_done;
  assign a_dout[1]  = 64'(if1.dout);
  assign a_state[1] = 64'(if1.state);
  assign a_v[1]     = if1.dout_valid;
  assign a_z[1]     = if1.seed_zero;
  assign a_p[1]     = if1.period_done;
  assign a_dout[2]  = 64'(if2.dout);
  assign a_state[2] = 64'(if2.state);
  assign a_v[2]     = if2.dout_valid;
  assign a_z[2]     = if2.seed_zero;
  assign a_p[2]     = if2.period_done;

  galois_lfsr_stream u0 (
    .clk   (clk),
    .reset (rst[0]),
    .bus   (if0)
  );

  galois_lfsr_stream #(
    .WIDTH (4),
    .POLY  (4'h9),
    .SEED  (4'h1),
    .STEPS (1)
  ) u1 (
    .clk   (clk),
    .reset (rst[1]),
    .bus   (if1)
  );

  galois_lfsr_stream #(
    .WIDTH (4),
    .POLY  (4'h9),
    .SEED  (4'h1),
    .STEPS (2)
  ) u2 (
    .clk   (clk),
    .reset (rst[2]),
    .bus   (if2)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;
  bit inj0   = 1'b0;

  task automatic cmp(input string nm, input int idx,
                     input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] t=%0t got %h expected %h",
               nm, idx, $time, act, exp);
    end
  endtask

  function automatic int wid(input int i);
    return (i == 0) ? 32 : 4;
  endfunction

  function automatic logic [63:0] mask(input int i);
    return (64'd1 << wid(i)) - 64'd1;
  endfunction

  function automatic logic [63:0] polyv(input int i);
    return (i == 0) ? 64'h8020_0003 : 64'h9;
  endfunction

  // Galois right shift as plain arithmetic: s' = (s>>1) ^ (lsb ? poly : 0)
  function automatic logic [63:0] adv(input int i, input logic [63:0] s);
    logic [63:0] r;
    r = s;
    for (int k = 0; k < ((i == 2) ? 2 : 1); k++) begin
      r = (r >> 1) ^ (r[0] ? polyv(i) : 64'd0);
    end
    return r;
  endfunction

  logic [63:0] m_state [3];
  logic [63:0] m_seed  [3];
  logic        m_v [3];
  logic        m_z [3];
  logic        m_p [3];

  always @(posedge clk) begin
    logic [63:0] cur;
    logic [63:0] nxt;
    logic [63:0] sv;
    for (int i = 0; i < 3; i++) begin
      cur = (i == 0 && inj0) ? 64'd0 : m_state[i];
      nxt = adv(i, cur);
      sv  = sin[i] & mask(i);
      if (rst[i]) begin
        m_state[i] <= 64'd1;
        m_seed[i]  <= 64'd1;
        m_v[i]     <= 1'b0;
        m_z[i]     <= 1'b0;
        m_p[i]     <= 1'b0;
      end else begin
        m_v[i] <= en[i];
        m_z[i] <= 1'b0;
        m_p[i] <= 1'b0;
        if (ld[i]) begin
          m_state[i] <= (sv == 0) ? 64'd1 : sv;
          m_seed[i]  <= (sv == 0) ? 64'd1 : sv;
          m_z[i]     <= (sv == 0);
          m_v[i]     <= 1'b0;
        end else if (cur == 0) begin
          m_state[i] <= 64'd1;
        end else if (m_v[i] && rdy[i]) begin
          m_state[i] <= nxt;
          m_p[i]     <= (nxt == m_seed[i]);
        end else begin
          m_state[i] <= cur;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 3; i++) begin
        cmp("dout", i, a_dout[i], m_state[i]);
        cmp("state", i, a_state[i], m_state[i]);
        cmp("valid", i, 64'(a_v[i]), 64'(m_v[i]));
        cmp("seed_zero", i, 64'(a_z[i]), 64'(m_z[i]));
        cmp("period_done", i, 64'(a_p[i]), 64'(m_p[i]));
      end
    end
  end

  initial begin
    logic [15:0] vis1;
    logic [15:0] vis2;
    int pd1;
    int pd2;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1;
      en[i]  = 1'b0;
      ld[i]  = 1'b0;
      rdy[i] = 1'b0;
      sin[i] = 64'd0;
    end
    repeat (2) @(negedge clk);
    chk_on = 1'b1;

    cmp("lit_model_step", 0, adv(0, 64'd1), 64'h8020_0003);
    cmp("lit_rst_state", 0, a_state[0], 64'd1);
    cmp("lit_rst_valid", 0, 64'(a_v[0]), 64'd0);

    // 4-bit full-period walk, STEPS=1 and STEPS=2
    for (int i = 1; i < 3; i++) begin
      rst[i] = 1'b0;
      en[i]  = 1'b1;
      rdy[i] = 1'b1;
    end
    @(negedge clk);
    vis1 = '0;
    vis2 = '0;
    pd1  = 0;
    pd2  = 0;
    for (int k = 0; k < 15; k++) begin
      vis1[a_dout[1][3:0]] = 1'b1;
      vis2[a_dout[2][3:0]] = 1'b1;
      @(negedge clk);
      pd1 += int'(a_p[1]);
      pd2 += int'(a_p[2]);
      if (k == 0) begin
        cmp("lit_w4_s1_second", 1, a_dout[1], 64'd9);
        cmp("lit_w4_s2_second", 2, a_dout[2], 64'd13);
      end
    end
    cmp("lit_w4_s1_visited", 1, 64'(vis1), 64'hFFFE);
    cmp("lit_w4_s2_visited", 2, 64'(vis2), 64'hFFFE);
    cmp("lit_w4_s1_pulses", 1, 64'(pd1), 64'd1);
    cmp("lit_w4_s2_pulses", 2, 64'(pd2), 64'd1);
    cmp("lit_w4_s1_pd_at15", 1, 64'(a_p[1]), 64'd1);
    cmp("lit_w4_s1_wrapped", 1, a_dout[1], 64'd1);

    // 32-bit default sequence and stall
    rst[0] = 1'b0;
    en[0]  = 1'b1;
    rdy[0] = 1'b1;
    @(negedge clk);
    cmp("lit_first_valid", 0, 64'(a_v[0]), 64'd1);
    cmp("lit_first_word", 0, a_dout[0], 64'h1);
    @(negedge clk);
    cmp("lit_second_word", 0, a_dout[0], 64'h8020_0003);
    rdy[0] = 1'b0;
    repeat (5) begin
      @(negedge clk);
      cmp("lit_stall_word", 0, a_dout[0], 64'h8020_0003);
      cmp("lit_stall_valid", 0, 64'(a_v[0]), 64'd1);
    end
    rdy[0] = 1'b1;
    @(negedge clk);
    cmp("lit_third_word", 0, a_dout[0], 64'hC030_0002);

    // zero seed load
    ld[0]  = 1'b1;
    sin[0] = 64'd0;
    @(negedge clk);
    ld[0] = 1'b0;
    cmp("lit_zero_seed_pulse", 0, 64'(a_z[0]), 64'd1);
    cmp("lit_zero_seed_state", 0, a_state[0], 64'd1);
    cmp("lit_zero_seed_valid", 0, 64'(a_v[0]), 64'd0);
    @(negedge clk);
    cmp("lit_zero_seed_end", 0, 64'(a_z[0]), 64'd0);

    // load concurrent with a live handshake
    ld[0]  = 1'b1;
    sin[0] = 64'h1234;
    @(negedge clk);
    ld[0] = 1'b0;
    cmp("lit_load_wins", 0, a_state[0], 64'h1234);
    cmp("lit_load_valid", 0, 64'(a_v[0]), 64'd0);
    repeat (2) @(negedge clk);

    // lock-up recovery with enable low
    en[0] = 1'b0;
    #1;
    force u0.state_q = '0;
    inj0 = 1'b1;
    #1;
    release u0.state_q;
    @(posedge clk);
    #1 inj0 = 1'b0;
    @(negedge clk);
    cmp("lit_lockup_state", 0, a_state[0], 64'd1);
    en[0] = 1'b1;
    repeat (3) @(negedge clk);

    // reset beats a simultaneous load
    ld[0]  = 1'b1;
    sin[0] = 64'h55;
    rst[0] = 1'b1;
    @(negedge clk);
    ld[0]  = 1'b0;
    rst[0] = 1'b0;
    cmp("lit_rst_mid_state", 0, a_state[0], 64'd1);
    cmp("lit_rst_mid_valid", 0, 64'(a_v[0]), 64'd0);
    cmp("lit_rst_mid_pd", 0, 64'(a_p[0]), 64'd0);

    // randomized traffic
    repeat (3000) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        en[i]  = ($urandom_range(0, 7) != 0);
        rdy[i] = ($urandom_range(0, 9) < 7);
        ld[i]  = ($urandom_range(0, 63) == 0);
        sin[i] = ($urandom_range(0, 3) == 0) ? 64'd0
               : {32'($urandom), 32'($urandom)};
        rst[i] = ($urandom_range(0, 999) == 0);
      end
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
